// File: rtl/pcs_pkg.sv
// Shared definitions for the 64b/66b receive block-lock logic.
package pcs_pkg;

  // Legal sync headers: data block and control block.
  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  // Block-lock controller states.
  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    SLIP_WAIT = 2'd1,
    LOCKED    = 2'd2
  } lock_state_t;

  // A header is valid only when its two bits differ.
  function automatic logic sh_is_valid(input logic [1:0] hdr);
    return (hdr == SH_DATA) || (hdr == SH_CTRL);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled increments and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Increment on request unless already at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pcs_block_lock_ctrl.sv
// Receive block-lock controller: hunts for sync-header alignment by slipping
// the gearbox, declares lock after a run of good headers, and drops lock when
// too many bad headers land in one monitoring window.
//
// Handshake: sh is sampled only on cycles with sh_valid=1; there is no ready,
// the controller accepts every valid header (and ignores all input while the
// gearbox settles after a slip). slip is a one-cycle request with no response.
//
// The current FSM state is held in state_q for observation.
module pcs_block_lock_ctrl #(
  parameter int LOCK_CNT   = 64,
  parameter int WINDOW     = 64,
  parameter int UNLOCK_ERR = 16,
  parameter int SLIP_WAIT  = 8,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sh_valid,
  input  logic [1:0]           sh,
  output logic                 slip,
  output logic                 block_lock,
  output logic                 descr_en,
  output logic [ERR_CNT_W-1:0] hdr_err_cnt
);

  import pcs_pkg::*;

  localparam logic [6:0] LOCK_CNT_C   = 7'(LOCK_CNT);
  localparam logic [6:0] WINDOW_C     = 7'(WINDOW);
  localparam logic [4:0] UNLOCK_ERR_C = 5'(UNLOCK_ERR);
  localparam logic [7:0] SLIP_WAIT_C  = 8'(SLIP_WAIT);

  lock_state_t state_q, state_d;
  logic [6:0]  sh_cnt_q, sh_cnt_d;
  logic [4:0]  inv_cnt_q, inv_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        slip_q, slip_d;
  logic        lock_q, lock_d;
  logic        err_inc;
  logic        hdr_ok;
  logic [6:0]  sh_next;
  logic [4:0]  inv_next;

  assign hdr_ok = sh_is_valid(sh);

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      sh_cnt_q   <= '0;
      inv_cnt_q  <= '0;
      wait_cnt_q <= '0;
      slip_q     <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      slip_q     <= slip_d;
      lock_q     <= lock_d;
    end
  end

  // Next-state and next-output logic for hunt / settle / locked operation.
  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    inv_cnt_d  = inv_cnt_q;
    wait_cnt_d = wait_cnt_q;
    slip_d     = 1'b0;
    lock_d     = lock_q;
    err_inc    = 1'b0;
    sh_next    = sh_cnt_q + 7'd1;
    inv_next   = inv_cnt_q + {4'd0, ~hdr_ok};

    case (state_q)
      HUNT: begin
        if (sh_valid) begin
          if (hdr_ok) begin
            if (sh_next == LOCK_CNT_C) begin
              state_d   = LOCKED;
              lock_d    = 1'b1;
              sh_cnt_d  = '0;
              inv_cnt_d = '0;
            end else begin
              sh_cnt_d = sh_next;
            end
          end else begin
            // Bad header while hunting: shift alignment and let the gearbox settle.
            state_d    = pcs_pkg::SLIP_WAIT;
            slip_d     = 1'b1;
            sh_cnt_d   = '0;
            wait_cnt_d = SLIP_WAIT_C;
          end
        end
      end

      pcs_pkg::SLIP_WAIT: begin
        // Loaded with SLIP_WAIT on entry, so leaving at 1 gives exactly
        // SLIP_WAIT cycles here; input is ignored throughout.
        if (wait_cnt_q <= 8'd1) begin
          wait_cnt_d = '0;
          state_d    = HUNT;
        end else begin
          wait_cnt_d = wait_cnt_q - 8'd1;
        end
      end

      LOCKED: begin
        if (sh_valid) begin
          err_inc = ~hdr_ok;
          if (inv_next == UNLOCK_ERR_C) begin
            // Unlock wins over a coincident window boundary.
            state_d    = pcs_pkg::SLIP_WAIT;
            lock_d     = 1'b0;
            slip_d     = 1'b1;
            sh_cnt_d   = '0;
            inv_cnt_d  = '0;
            wait_cnt_d = SLIP_WAIT_C;
          end else if (sh_next == WINDOW_C) begin
            sh_cnt_d  = '0;
            inv_cnt_d = '0;
          end else begin
            sh_cnt_d  = sh_next;
            inv_cnt_d = inv_next;
          end
        end
      end

      default: begin
        state_d = HUNT;
      end
    endcase
  end

  sat_counter #(
    .W(ERR_CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (err_inc),
    .cnt  (hdr_err_cnt)
  );

  assign slip       = slip_q;
  assign block_lock = lock_q;
  assign descr_en   = lock_q;

endmodule
